// File: rtl/capture_pkg.sv
// capture_pkg
// Shared definitions for the triggered AXI-Stream capture block.
//   FIFO_DEPTH  : number of entries in the output skid FIFO
//   OCC_W       : width of the FIFO occupancy count
//   cap_state_t : capture FSM state encoding
package capture_pkg;

    localparam int FIFO_DEPTH = 2;
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FLUSH   = 2'd3
    } cap_state_t;

endpackage

// File: rtl/axis_skid_fifo2.sv
// axis_skid_fifo2
// Two-entry FIFO carrying {tdata, tlast} with registered read-side outputs.
// The head entry drives the read port directly, and the tail entry holds a
// second beat while the consumer stalls.
// Ports:
//   aclk, resetn          : clock, synchronous active-low reset
//   wr_en, wr_data,
//   wr_last               : write side; caller only writes when space exists
//   rd_ready              : consumer ready
//   rd_valid, rd_data,
//   rd_last               : read side, rd_valid = not empty
//   pop                   : read handshake this cycle
//   occupancy             : number of stored entries
module axis_skid_fifo2
    import capture_pkg::*;
#(
    parameter int TDATA_WIDTH = 32
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [TDATA_WIDTH-1:0] wr_data,
    input  logic                   wr_last,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [TDATA_WIDTH-1:0] rd_data,
    output logic                   rd_last,
    output logic                   pop,
    output logic [OCC_W-1:0]       occupancy
);

    localparam logic [OCC_W-1:0] OCC_EMPTY = '0;
    localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

    logic [OCC_W-1:0]       occ;
    logic [TDATA_WIDTH-1:0] head_data;
    logic                   head_last;
    logic [TDATA_WIDTH-1:0] tail_data;
    logic                   tail_last;

    assign rd_valid  = (occ != OCC_EMPTY);
    assign rd_data   = head_data;
    assign rd_last   = head_last;
    assign pop       = rd_valid & rd_ready;
    assign occupancy = occ;

    // Head/tail shift structure. head_last is cleared when the FIFO drains so
    // that tlast never shows 1 while tvalid is 0.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            occ       <= OCC_EMPTY;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else if (pop) begin
            if (occ == OCC_FULL) begin
                head_data <= tail_data;
                head_last <= tail_last;
                if (wr_en) begin
                    tail_data <= wr_data;
                    tail_last <= wr_last;
                end else begin
                    occ <= OCC_ONE;
                end
            end else if (wr_en) begin
                head_data <= wr_data;
                head_last <= wr_last;
            end else begin
                occ       <= OCC_EMPTY;
                head_last <= 1'b0;
            end
        end else if (wr_en) begin
            if (occ == OCC_EMPTY) begin
                head_data <= wr_data;
                head_last <= wr_last;
                occ       <= OCC_ONE;
            end else if (occ == OCC_ONE) begin
                tail_data <= wr_data;
                tail_last <= wr_last;
                occ       <= OCC_FULL;
            end
        end
    end

endmodule

// File: rtl/axis_trig_capture.sv
// axis_trig_capture
// Captures a fixed-length packet of CAPTURE_LEN samples from a free-running
// ADC stream, starting at the first triggered sample after an arm request.
// Samples that find no room in the output FIFO are dropped (flagged by the
// sticky overflow bit) so every packet is exactly CAPTURE_LEN beats long.
// Ports:
//   aclk, resetn                        : clock, synchronous active-low reset
//   s_axis_tvalid/tdata/tready          : sample input, never stalled
//   m_axis_tvalid/tready/tdata/tlast    : packet output
//   arm, abort, trig                    : capture control
//   busy, armed, done, overflow         : status
module axis_trig_capture
    import capture_pkg::*;
#(
    parameter int TDATA_WIDTH = 32,
    parameter int CAPTURE_LEN = 1024
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic                   s_axis_tvalid,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    output logic                   s_axis_tready,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tlast,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   trig,
    output logic                   busy,
    output logic                   armed,
    output logic                   done,
    output logic                   overflow
);

    localparam int               CNT_W     = $clog2(CAPTURE_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CAPTURE_LEN - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

    cap_state_t       state;
    cap_state_t       state_next;
    logic [CNT_W-1:0] beat_cnt;
    logic             wr_en;
    logic             wr_last;
    logic             drop;
    logic             flush_done;
    logic             fifo_pop;
    logic [OCC_W-1:0] occupancy;
    logic             has_space;

    assign s_axis_tready = 1'b1;

    // A full FIFO still accepts a write when its head leaves in the same cycle.
    assign has_space = (occupancy < OCC_FULL) || fifo_pop;

    axis_skid_fifo2 #(
        .TDATA_WIDTH (TDATA_WIDTH)
    ) u_fifo (
        .aclk      (aclk),
        .resetn    (resetn),
        .wr_en     (wr_en),
        .wr_data   (s_axis_tdata),
        .wr_last   (wr_last),
        .rd_ready  (m_axis_tready),
        .rd_valid  (m_axis_tvalid),
        .rd_data   (m_axis_tdata),
        .rd_last   (m_axis_tlast),
        .pop       (fifo_pop),
        .occupancy (occupancy)
    );

    // State register.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort wins over a trigger in the same ARMED cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (arm) state_next = ST_ARMED;
            ST_ARMED: begin
                if (abort)      state_next = ST_IDLE;
                else if (wr_en) state_next = wr_last ? ST_FLUSH : ST_CAPTURE;
            end
            ST_CAPTURE: if (wr_en && wr_last) state_next = ST_FLUSH;
            ST_FLUSH:   if (flush_done) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Output logic: FIFO write, drop detection and status decode.
    always_comb begin
        wr_en      = 1'b0;
        wr_last    = 1'b0;
        drop       = 1'b0;
        flush_done = 1'b0;
        busy       = (state != ST_IDLE);
        armed      = (state == ST_ARMED);
        unique case (state)
            ST_ARMED: begin
                if (!abort && s_axis_tvalid && trig) begin
                    wr_en   = 1'b1;
                    wr_last = (beat_cnt == LAST_BEAT);
                end
            end
            ST_CAPTURE: begin
                if (s_axis_tvalid) begin
                    if (has_space) begin
                        wr_en   = 1'b1;
                        wr_last = (beat_cnt == LAST_BEAT);
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_FLUSH:   flush_done = fifo_pop && m_axis_tlast;
            default:    ;
        endcase
    end

    // Written-beat counter; reaches CAPTURE_LEN at most, so it cannot wrap.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            beat_cnt <= '0;
        end else if (state == ST_IDLE && arm) begin
            beat_cnt <= '0;
        end else if (wr_en) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    // Sticky overflow, cleared when a new capture is armed; done pulse.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= flush_done;
            if (state == ST_IDLE && arm) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_trig_capture.sv
// tb_axis_trig_capture
// Table-driven, directed and randomized checks of axis_trig_capture against
// a queue-based reference model (CAPTURE_LEN=4), plus a CAPTURE_LEN=1 copy.
module tb_axis_trig_capture;

    localparam int W   = 32;
    localparam int LEN = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_CAPT  = 2;
    localparam int M_FLUSH = 3;

    logic         aclk = 1'b0;
    logic         resetn;
    logic         s_axis_tvalid;
    logic [W-1:0] s_axis_tdata;
    logic         m_axis_tready;
    logic         arm, abort, trig;

    logic         s_axis_tready, m_axis_tvalid, m_axis_tlast;
    logic [W-1:0] m_axis_tdata;
    logic         busy, armed, done, overflow;

    logic         s1_tready, m1_tvalid, m1_tlast;
    logic [W-1:0] m1_tdata;
    logic         busy1, armed1, done1, overflow1;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    typedef struct {
        logic         arm, abort, trig, tvalid;
        logic [W-1:0] tdata;
        logic         tready;
        logic         e_valid;
        logic [W-1:0] e_data;
        logic         e_last, e_busy, e_armed, e_done, e_ovf;
    } vec_t;

    int    errors = 0;
    int    checks = 0;

    beat_t mq[$];
    beat_t seen[$];
    int    m_mode = M_IDLE;
    int    m_written = 0;
    logic  m_ovf = 1'b0;
    logic  m_done = 1'b0;

    axis_trig_capture #(.TDATA_WIDTH(W), .CAPTURE_LEN(LEN)) dut (
        .aclk(aclk), .resetn(resetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .arm(arm), .abort(abort), .trig(trig),
        .busy(busy), .armed(armed), .done(done), .overflow(overflow)
    );

    axis_trig_capture #(.TDATA_WIDTH(W), .CAPTURE_LEN(1)) dut1 (
        .aclk(aclk), .resetn(resetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s1_tready),
        .m_axis_tvalid(m1_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m1_tdata), .m_axis_tlast(m1_tlast),
        .arm(arm), .abort(abort), .trig(trig),
        .busy(busy1), .armed(armed1), .done(done1), .overflow(overflow1)
    );

    always #5 aclk = ~aclk;

    function automatic void check1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endfunction

    function automatic void check32(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: one clock edge, driven by the inputs present before it.
    function automatic void modelStep(logic rn, logic a, logic ab, logic tg,
                                      logic tv, logic [W-1:0] td, logic tr);
        logic  pop;
        logic  accept;
        beat_t b;
        if (!rn) begin
            m_mode = M_IDLE; m_written = 0; m_ovf = 1'b0; m_done = 1'b0;
            mq.delete();
            return;
        end
        pop    = (mq.size() > 0) && tr;
        accept = 1'b0;
        m_done = 1'b0;
        b.data = td;
        b.last = 1'b0;
        case (m_mode)
            M_IDLE: if (a) begin m_mode = M_ARMED; m_ovf = 1'b0; m_written = 0; end
            M_ARMED: begin
                if (ab) m_mode = M_IDLE;
                else if (tv && tg) begin
                    accept = 1'b1;
                    b.last = (LEN == 1);
                    m_written = 1;
                    m_mode = (LEN == 1) ? M_FLUSH : M_CAPT;
                end
            end
            M_CAPT: begin
                if (tv) begin
                    if (mq.size() < 2 || pop) begin
                        accept = 1'b1;
                        b.last = (m_written == LEN - 1);
                        m_written++;
                        if (m_written == LEN) m_mode = M_FLUSH;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            default: if (pop && mq[0].last) begin m_mode = M_IDLE; m_done = 1'b1; end
        endcase
        if (pop) void'(mq.pop_front());
        if (accept) mq.push_back(b);
    endfunction

    task automatic checkOutput();
        logic exp_valid;
        exp_valid = (mq.size() > 0);
        check1("s_tready", s_axis_tready, 1'b1);
        check1("m_tvalid", m_axis_tvalid, exp_valid);
        check1("m_tlast", m_axis_tlast, exp_valid ? mq[0].last : 1'b0);
        if (exp_valid) check32("m_tdata", m_axis_tdata, mq[0].data);
        check1("busy", busy, m_mode != M_IDLE);
        check1("armed", armed, m_mode == M_ARMED);
        check1("done", done, m_done);
        check1("overflow", overflow, m_ovf);
    endtask

    task automatic applyStimulus(logic rn, logic a, logic ab, logic tg,
                                 logic tv, logic [W-1:0] td, logic tr);
        resetn = rn; arm = a; abort = ab; trig = tg;
        s_axis_tvalid = tv; s_axis_tdata = td; m_axis_tready = tr;
        if (m_axis_tvalid === 1'b1 && tr) seen.push_back('{m_axis_tdata, m_axis_tlast});
        modelStep(rn, a, ab, tg, tv, td, tr);
        @(posedge aclk);
        #1;
        checkOutput();
    endtask

    task automatic checkSeen(string name, logic [W-1:0] d0, logic [W-1:0] d1,
                             logic [W-1:0] d2, logic [W-1:0] d3);
        logic [W-1:0] exp_d [4];
        exp_d = '{d0, d1, d2, d3};
        check32({name, "_count"}, W'(seen.size()), W'(4));
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            check32({name, "_data"}, seen[i].data, exp_d[i]);
            check1({name, "_last"}, seen[i].last, i == 3);
        end
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h05, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h12, 1'b1, 1'b1, 32'h12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h13, 1'b1, 1'b1, 32'h13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h15, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h16, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h17, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h21, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        resetn = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;

        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 1'b1);

        // Basic packet, then trig without arm, then abort beating trig
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, vecs[i].arm, vecs[i].abort, vecs[i].trig,
                          vecs[i].tvalid, vecs[i].tdata, vecs[i].tready);
            check1("vec_tvalid", m_axis_tvalid, vecs[i].e_valid);
            check1("vec_tlast", m_axis_tlast, vecs[i].e_last);
            if (vecs[i].e_valid) check32("vec_tdata", m_axis_tdata, vecs[i].e_data);
            check1("vec_busy", busy, vecs[i].e_busy);
            check1("vec_armed", armed, vecs[i].e_armed);
            check1("vec_done", done, vecs[i].e_done);
            check1("vec_ovf", overflow, vecs[i].e_ovf);
        end

        // Output stalled from the trigger cycle for 5 cycles: 3 samples lost
        seen.delete();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0F, 1'b1);
        for (int k = 0; k < 11; k++)
            applyStimulus(1'b1, 1'b0, 1'b0, k == 0, 1'b1, W'(32'h10 + k), k >= 5);
        checkSeen("stall", 32'h10, 32'h11, 32'h15, 32'h16);
        check1("stall_ovf", overflow, 1'b1);

        // Reset after the second beat is written, then a fresh packet
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0F, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12, 1'b1);
        check1("rst_tvalid", m_axis_tvalid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_ovf", overflow, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h13, 1'b1);
        seen.delete();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3F, 1'b1);
        for (int k = 0; k < 8; k++)
            applyStimulus(1'b1, 1'b0, 1'b0, k == 0, 1'b1, W'(32'h40 + k), 1'b1);
        checkSeen("after_rst", 32'h40, 32'h41, 32'h42, 32'h43);

        // Arm during capture is ignored
        seen.delete();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2F, 1'b1);
        for (int k = 0; k < 6; k++)
            applyStimulus(1'b1, k == 1 || k == 2, 1'b0, k == 0, 1'b1, W'(32'h30 + k), 1'b1);
        checkSeen("arm_in_cap", 32'h30, 32'h31, 32'h32, 32'h33);
        check1("arm_in_cap_busy", busy, 1'b0);
        check1("arm_in_cap_armed", armed, 1'b0);

        // CAPTURE_LEN=1 instance
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check1("len1_armed", armed1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAA, 1'b1);
        check1("len1_tvalid", m1_tvalid, 1'b1);
        check32("len1_tdata", m1_tdata, 32'hAA);
        check1("len1_tlast", m1_tlast, 1'b1);
        check1("len1_busy", busy1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check1("len1_tvalid_after", m1_tvalid, 1'b0);
        check1("len1_done", done1, 1'b1);
        check1("len1_busy_after", busy1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check1("len1_done_once", done1, 1'b0);
        check1("len1_s_tready", s1_tready, 1'b1);

        // Randomized traffic against the model
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 299) != 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) != 0,
                          W'($urandom),
                          $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
